// File: rtl/sync_fifo_param.sv
// Single-clock parameterised FIFO with occupancy flags, sticky error flags,
// synchronous flush, and a choice of first-word-fall-through or registered read.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 47,
  parameter int DEPTH      = 16,
  parameter int AFULL_TH   = DEPTH - 2,
  parameter int AEMPTY_TH  = 2,
  parameter int FWFT       = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    pop,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          push_ok, pop_ok;

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Acceptance looks only at pre-edge flags, so a same-cycle pop never makes room.
  always_comb begin
    push_ok     = push & ~full  & ~flush;
    pop_ok      = pop  & ~empty & ~flush;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q  | (push & full  & ~flush);
    underflow_d = underflow_q | (pop  & empty & ~flush);

    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + AW'(1);
      if (pop_ok)  rptr_d = rptr_q + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wptr_q] <= wdata;
  end

  if (FWFT != 0) begin : g_fwft
    assign rdata = mem_q[rptr_q];
  end else begin : g_reg_read
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    always_comb begin
      rdata_d = rdata_q;
      if (pop_ok) rdata_d = mem_q[rptr_q];
    end

    always_ff @(posedge clk) begin
      if (rst) rdata_q <= '0;
      else     rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: one FWFT instance and one registered-read
// instance share the same stimulus; expected values are written out by hand.
module tb_sync_fifo_param;

  localparam int DW = 47;

  logic          clk = 1'b0;
  logic          rst, flush, push, pop;
  logic [DW-1:0] wdata;

  logic [DW-1:0] rdata_f, rdata_r;
  logic          full_f, empty_f, afull_f, aempty_f, ovf_f, udf_f;
  logic          full_r, empty_r, afull_r, aempty_r, ovf_r, udf_r;
  logic [4:0]    count_f, count_r;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(16), .FWFT(1)) u_dut_fwft (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .wdata(wdata), .pop(pop),
    .rdata(rdata_f), .full(full_f), .empty(empty_f), .almost_full(afull_f),
    .almost_empty(aempty_f), .count(count_f), .overflow(ovf_f), .underflow(udf_f)
  );

  sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(16), .FWFT(0)) u_dut_reg (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .wdata(wdata), .pop(pop),
    .rdata(rdata_r), .full(full_r), .empty(empty_r), .almost_full(afull_r),
    .almost_empty(aempty_r), .count(count_r), .overflow(ovf_r), .underflow(udf_r)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0; wdata = '0;
    tick(); tick();
    rst = 1'b0;

    check("rst_count",  64'(count_f), 0);
    check("rst_empty",  64'(empty_f), 1);
    check("rst_full",   64'(full_f), 0);
    check("rst_aempty", 64'(aempty_f), 1);
    check("rst_afull",  64'(afull_f), 0);
    check("rst_ovf",    64'(ovf_f), 0);
    check("rst_udf",    64'(udf_f), 0);
    check("rst_rdata_r", 64'(rdata_r), 0);
    check("rst_flags_r", 64'({full_r, empty_r, afull_r, aempty_r, ovf_r, udf_r}), 64'b010100);

    // Fill with 1..16, then drain in order.
    for (int i = 1; i <= 16; i++) begin
      push = 1'b1; wdata = DW'(i);
      tick();
      check($sformatf("fill_count%0d", i),  64'(count_f), 64'(i));
      check($sformatf("fill_full%0d", i),   64'(full_f), 64'(i == 16));
      check($sformatf("fill_afull%0d", i),  64'(afull_f), 64'(i >= 14));
      check($sformatf("fill_aempty%0d", i), 64'(aempty_f), 64'(i <= 2));
    end
    push = 1'b0;
    check("fill_count_r", 64'(count_r), 16);
    for (int i = 1; i <= 16; i++) begin
      check($sformatf("drain_fwft%0d", i), 64'(rdata_f), 64'(i));
      pop = 1'b1;
      tick();
      check($sformatf("drain_reg%0d", i),   64'(rdata_r), 64'(i));
      check($sformatf("drain_count%0d", i), 64'(count_f), 64'(16 - i));
    end
    pop = 1'b0;
    check("drain_empty", 64'(empty_f), 1);
    check("drain_errs",  64'({ovf_f, udf_f}), 0);

    // Full FIFO: simultaneous push+pop pops only and flags overflow.
    for (int i = 0; i < 16; i++) begin
      push = 1'b1; wdata = DW'(32'h21 + 32'(i));
      tick();
    end
    push = 1'b0;
    check("full_before", 64'(full_f), 1);
    push = 1'b1; pop = 1'b1; wdata = DW'(32'hDEAD);
    tick();
    push = 1'b0; pop = 1'b0;
    check("fullpp_count", 64'(count_f), 15);
    check("fullpp_ovf",   64'(ovf_f), 1);
    check("fullpp_udf",   64'(udf_f), 0);
    check("fullpp_full",  64'(full_f), 0);
    check("fullpp_rdata_r", 64'(rdata_r), 64'h21);
    for (int i = 1; i < 16; i++) begin
      check($sformatf("fullpp_drain%0d", i), 64'(rdata_f), 64'(32'h21 + 32'(i)));
      pop = 1'b1;
      tick();
    end
    pop = 1'b0;
    check("fullpp_empty", 64'(empty_f), 1);
    check("fullpp_last_r", 64'(rdata_r), 64'h30);

    // Empty FIFO: simultaneous push+pop pushes only and flags underflow.
    push = 1'b1; pop = 1'b1; wdata = 47'h7FFF_FFFF_FFFF;
    tick();
    push = 1'b0; pop = 1'b0;
    check("emptypp_count", 64'(count_f), 1);
    check("emptypp_udf",   64'(udf_f), 1);
    check("emptypp_fwft",  64'(rdata_f), 64'h7FFF_FFFF_FFFF);
    check("emptypp_reg_hold", 64'(rdata_r), 64'h30);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    check("emptypp_reg_pop", 64'(rdata_r), 64'h7FFF_FFFF_FFFF);
    check("emptypp_count0",  64'(count_f), 0);

    // Reset with data in flight; a push during reset is ignored.
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; wdata = DW'(32'h55 + 32'(i));
      tick();
    end
    push = 1'b0;
    check("mid_count", 64'(count_f), 3);
    rst = 1'b1; push = 1'b1; wdata = DW'(32'h99);
    tick();
    rst = 1'b0; push = 1'b0;
    check("mid_rst_count", 64'(count_f), 0);
    check("mid_rst_count_r", 64'(count_r), 0);
    check("mid_rst_flags", 64'({full_f, empty_f, afull_f, aempty_f, ovf_f, udf_f}), 64'b010100);
    check("mid_rst_rdata_r", 64'(rdata_r), 0);

    // Streaming at count=8 across several pointer wraps.
    for (int k = 0; k < 8; k++) begin
      push = 1'b1; wdata = DW'(32'h100 + 32'(k));
      tick();
    end
    push = 1'b0;
    for (int j = 0; j < 40; j++) begin
      check($sformatf("stream_fwft%0d", j), 64'(rdata_f), 64'(32'h100 + 32'(j)));
      push = 1'b1; pop = 1'b1; wdata = DW'(32'h108 + 32'(j));
      tick();
      check($sformatf("stream_count%0d", j), 64'(count_f), 8);
      check($sformatf("stream_reg%0d", j),   64'(rdata_r), 64'(32'h100 + 32'(j)));
    end
    push = 1'b0; pop = 1'b0;
    check("stream_errs", 64'({ovf_f, udf_f}), 0);

    // Flush behaviour.
    for (int j = 0; j < 3; j++) begin
      check($sformatf("preflush_pop%0d", j), 64'(rdata_f), 64'(32'h128 + 32'(j)));
      pop = 1'b1;
      tick();
    end
    pop = 1'b0;
    check("preflush_count", 64'(count_f), 5);
    flush = 1'b1; push = 1'b1; pop = 1'b1; wdata = DW'(32'hBAD);
    tick();
    push = 1'b0;
    check("flush_count", 64'(count_f), 0);
    check("flush_empty", 64'(empty_f), 1);
    check("flush_errs",  64'({ovf_f, udf_f}), 0);
    check("flush_rdata_r", 64'(rdata_r), 64'h12A);
    tick();
    check("flush_pop_noudf", 64'(udf_f), 0);
    flush = 1'b0;
    tick();
    pop = 1'b0;
    check("udf_set", 64'(udf_f), 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_udf_kept", 64'(udf_f), 1);
    check("flush_count2",   64'(count_f), 0);
    push = 1'b1; wdata = DW'(32'hA);
    tick();
    push = 1'b0;
    check("postflush_count", 64'(count_f), 1);
    check("postflush_fwft",  64'(rdata_f), 64'hA);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    check("postflush_reg",   64'(rdata_r), 64'hA);
    check("postflush_empty", 64'(empty_f), 1);

    // Registered read: load on pop edge, hold otherwise, cleared by reset.
    push = 1'b1; wdata = DW'(32'h3);
    tick();
    push = 1'b0;
    check("reg_nopop_hold", 64'(rdata_r), 64'hA);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    check("reg_pop", 64'(rdata_r), 64'h3);
    push = 1'b1; wdata = DW'(32'h4);
    tick();
    push = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reg_hold%0d", i), 64'(rdata_r), 64'h3);
      tick();
    end
    push = 1'b1; wdata = DW'(32'h5);
    tick();
    push = 1'b0;
    check("reg_count", 64'(count_r), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("reg_rst_count", 64'(count_r), 0);
    check("reg_rst_rdata", 64'(rdata_r), 0);
    check("reg_rst_flags", 64'({full_r, empty_r, afull_r, aempty_r, ovf_r, udf_r}), 64'b010100);
    check("fwft_rst_udf",  64'(udf_f), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
